// File: rtl/centroid_scheduler_pkg.sv
// Shared FSM state encoding and output-field widths/saturation limits for
// centroid_scheduler.
package centroid_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SNAP   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  localparam int X_W    = 11;
  localparam int Y_W    = 10;
  localparam int AREA_W = 16;

  localparam logic [X_W-1:0]    X_MAX    = 11'd2047;
  localparam logic [Y_W-1:0]    Y_MAX    = 10'd1023;
  localparam logic [AREA_W-1:0] AREA_MAX = 16'hFFFF;

endpackage

// File: rtl/centroid_scheduler_div.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, WIDTH
// cycles per division, single-cycle data_valid_out when the result is ready.
module centroid_scheduler_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             data_valid_out,
  output logic             error_out,
  output logic             busy_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, rem_q, den_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, valid_q, err_q;
  logic [WIDTH:0]   rem_shift_s, diff_s;
  logic             fits_s;

  // trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    rem_shift_s = {rem_q, quo_q[WIDTH-1]};
    diff_s      = rem_shift_s - {1'b0, den_q};
    fits_s      = ~diff_s[WIDTH];
  end

  // iteration state; division by zero reports an error instead of iterating
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      quo_q   <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      den_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (start_in && !busy_q) begin
        if (divisor_in == {WIDTH{1'b0}}) begin
          quo_q   <= {WIDTH{1'b1}};
          rem_q   <= dividend_in;
          err_q   <= 1'b1;
          valid_q <= 1'b1;
        end else begin
          quo_q  <= dividend_in;
          rem_q  <= {WIDTH{1'b0}};
          den_q  <= divisor_in;
          cnt_q  <= CNT_W'(WIDTH);
          busy_q <= 1'b1;
          err_q  <= 1'b0;
        end
      end else if (busy_q) begin
        rem_q <= fits_s ? diff_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], fits_s};
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign quotient_out   = quo_q;
  assign remainder_out  = rem_q;
  assign data_valid_out = valid_q;
  assign error_out      = err_q;
  assign busy_out       = busy_q;

endmodule

// File: rtl/centroid_scheduler.sv
// Snapshots per-cluster sums/counts and resolves K centroids through one shared
// divider. Define CENTROID_ROUND_EN for round-to-nearest instead of floor.
module centroid_scheduler
  import centroid_scheduler_pkg::*;
#(
  parameter int K     = 4,
  parameter int WIDTH = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              tabulate_in,
  input  logic [WIDTH-1:0]  x_sum_in [K-1:0],
  input  logic [WIDTH-1:0]  y_sum_in [K-1:0],
  input  logic [WIDTH-1:0]  count_in [K-1:0],
  output logic              busy_out,
  output logic [X_W-1:0]    x_out    [K-1:0],
  output logic [Y_W-1:0]    y_out    [K-1:0],
  output logic [AREA_W-1:0] area_out [K-1:0],
  output logic [K-1:0]      valid_out,
  output logic              done_out
);

  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   xs_q [K-1:0];
  logic [WIDTH-1:0]   ys_q [K-1:0];
  logic [WIDTH-1:0]   cnt_q [K-1:0];
  logic [IDX_W-1:0]   idx_q;
  logic               axis_q;
  logic [X_W-1:0]     x_q [K-1:0];
  logic [Y_W-1:0]     y_q [K-1:0];
  logic [AREA_W-1:0]  area_q [K-1:0];
  logic [K-1:0]       valid_q;
  logic               busy_q, done_q;

  logic               skip_s, last_s, div_start_s, div_valid_s;
  logic [WIDTH-1:0]   sel_sum_s, dividend_s, div_quo_s, div_rem_s;
  logic               div_err_s, div_busy_s, div_unused_s;
  logic [X_W-1:0]     x_sat_s;
  logic [Y_W-1:0]     y_sat_s;

  assign skip_s = (cnt_q[idx_q] == {WIDTH{1'b0}});
  assign last_s = (idx_q == IDX_W'(K - 1));

  // state register
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic; an empty cluster costs one ISSUE cycle and no division
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (tabulate_in) state_d = ST_SNAP; else state_d = ST_IDLE;
      ST_SNAP:   state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (skip_s) state_d = last_s ? ST_FINISH : ST_ISSUE;
        else        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (div_valid_s) state_d = (axis_q && last_s) ? ST_FINISH : ST_ISSUE;
        else             state_d = ST_WAIT;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: divider launch
  always_comb begin
    div_start_s = 1'b0;
    if (state_q == ST_ISSUE) div_start_s = ~skip_s;
    else                     div_start_s = 1'b0;
  end

  // operand selection and quotient saturation
  always_comb begin
    sel_sum_s = axis_q ? ys_q[idx_q] : xs_q[idx_q];
`ifdef CENTROID_ROUND_EN
    begin
      logic [WIDTH:0] rnd_s;
      rnd_s = {1'b0, sel_sum_s} + {1'b0, (cnt_q[idx_q] >> 1)};
      if (rnd_s[WIDTH]) dividend_s = {WIDTH{1'b1}};
      else              dividend_s = rnd_s[WIDTH-1:0];
    end
`else
    dividend_s = sel_sum_s;
`endif
    if (div_quo_s > WIDTH'(X_MAX)) x_sat_s = X_MAX;
    else                           x_sat_s = div_quo_s[X_W-1:0];
    if (div_quo_s > WIDTH'(Y_MAX)) y_sat_s = Y_MAX;
    else                           y_sat_s = div_quo_s[Y_W-1:0];
  end

  // snapshot, sequencing index and registered results
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < K; i++) begin
        xs_q[i]   <= {WIDTH{1'b0}};
        ys_q[i]   <= {WIDTH{1'b0}};
        cnt_q[i]  <= {WIDTH{1'b0}};
        x_q[i]    <= {X_W{1'b0}};
        y_q[i]    <= {Y_W{1'b0}};
        area_q[i] <= {AREA_W{1'b0}};
      end
      idx_q   <= {IDX_W{1'b0}};
      axis_q  <= 1'b0;
      valid_q <= {K{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_d == ST_FINISH);
      busy_q <= (state_d != ST_IDLE);
      if (state_q == ST_IDLE && tabulate_in) begin
        valid_q <= {K{1'b0}};
        for (int i = 0; i < K; i++) begin
          xs_q[i]  <= x_sum_in[i];
          ys_q[i]  <= y_sum_in[i];
          cnt_q[i] <= count_in[i];
          if (count_in[i] > WIDTH'(AREA_MAX)) area_q[i] <= AREA_MAX;
          else                                area_q[i] <= count_in[i][AREA_W-1:0];
        end
      end
      case (state_q)
        ST_SNAP: begin
          idx_q  <= {IDX_W{1'b0}};
          axis_q <= 1'b0;
        end
        ST_ISSUE: if (skip_s) idx_q <= idx_q + IDX_W'(1);
        ST_WAIT: begin
          if (div_valid_s) begin
            if (axis_q) begin
              y_q[idx_q]     <= y_sat_s;
              valid_q[idx_q] <= 1'b1;
              axis_q         <= 1'b0;
              idx_q          <= idx_q + IDX_W'(1);
            end else begin
              x_q[idx_q] <= x_sat_s;
              axis_q     <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  centroid_scheduler_div #(.WIDTH(WIDTH)) u_div (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (div_start_s),
    .dividend_in   (dividend_s),
    .divisor_in    (cnt_q[idx_q]),
    .quotient_out  (div_quo_s),
    .remainder_out (div_rem_s),
    .data_valid_out(div_valid_s),
    .error_out     (div_err_s),
    .busy_out      (div_busy_s)
  );

  assign div_unused_s = ^{div_rem_s, div_err_s, div_busy_s};

  assign busy_out  = busy_q;
  assign done_out  = done_q;
  assign valid_out = valid_q;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign area_out  = area_q;

endmodule

// File: tb/tb_centroid_scheduler.sv
// Directed and randomized checks of centroid_scheduler against a plain
// arithmetic model of per-cluster centroids, areas and completion timing.
module tb_centroid_scheduler;
  import centroid_scheduler_pkg::*;

  localparam int K     = 4;
  localparam int LIMIT = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        tabulate;
  logic [31:0] xs [3:0];
  logic [31:0] ys [3:0];
  logic [31:0] cs [3:0];
  logic        busy, done;
  logic [10:0] xo [3:0];
  logic [9:0]  yo [3:0];
  logic [15:0] ao [3:0];
  logic [3:0]  vo;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int start_cnt = 0;

  longint unsigned mx [4];
  longint unsigned my [4];
  longint unsigned ma [4];
  bit              mv [4];

  centroid_scheduler #(.K(K), .WIDTH(32)) dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .tabulate_in(tabulate),
    .x_sum_in   (xs),
    .y_sum_in   (ys),
    .count_in   (cs),
    .busy_out   (busy),
    .x_out      (xo),
    .y_out      (yo),
    .area_out   (ao),
    .valid_out  (vo),
    .done_out   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt++;
    if (dut.div_start_s) start_cnt++;
  end

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint unsigned cdiv(longint unsigned s, longint unsigned c,
                                           longint unsigned maxv);
    longint unsigned d;
    d = s;
`ifdef CENTROID_ROUND_EN
    d = s + c / 2;
    if (d > 64'hFFFF_FFFF) d = 64'hFFFF_FFFF;
`endif
    d = d / c;
    return (d > maxv) ? maxv : d;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < K; i++) begin
      mx[i] = 0; my[i] = 0; ma[i] = 0; mv[i] = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < K; i++) begin
      chk($sformatf("%s x_out[%0d]", tag, i), xo[i], mx[i]);
      chk($sformatf("%s y_out[%0d]", tag, i), yo[i], my[i]);
      chk($sformatf("%s area_out[%0d]", tag, i), ao[i], ma[i]);
      chk($sformatf("%s valid_out[%0d]", tag, i), vo[i], mv[i]);
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < K; i++) begin
      xs[i] = $urandom;
      ys[i] = $urandom;
      cs[i] = $urandom_range(0, 9);
    end
  endtask

  // Pulse tabulate, optionally pulse it again while busy, and wait for done.
  task automatic run(input string tag, input int second_at, output int lat);
    logic [31:0] sx [3:0];
    logic [31:0] sy [3:0];
    logic [31:0] sc [3:0];
    int base_d, base_s, nz;
    sx = xs; sy = ys; sc = cs;
    base_d = done_cnt;
    base_s = start_cnt;
    @(negedge clk);
    tabulate = 1'b1;
    lat = 0;
    while (1) begin
      @(posedge clk); #1;
      tabulate = 1'b0;
      lat++;
      if (lat == 1) scramble();
      if (second_at != 0 && lat == second_at) begin
        scramble();
        tabulate = 1'b1;
      end
      if (done || lat >= LIMIT) break;
    end
    chk({tag, " done_in_time"}, (lat < LIMIT), 1);
    chk({tag, " busy_at_done"}, busy, 1);
    repeat (6) @(posedge clk);
    #1;
    chk({tag, " busy_after_done"}, busy, 0);
    chk({tag, " done_pulses"}, done_cnt - base_d, 1);
    nz = 0;
    for (int i = 0; i < K; i++) begin
      ma[i] = (sc[i] > 65535) ? 65535 : sc[i];
      mv[i] = (sc[i] != 0);
      if (sc[i] != 0) begin
        nz++;
        mx[i] = cdiv(sx[i], sc[i], 2047);
        my[i] = cdiv(sy[i], sc[i], 1023);
      end
    end
    chk({tag, " divider_starts"}, start_cnt - base_s, 2 * nz);
    check_outputs(tag);
  endtask

  task automatic load_req033();
    xs[0] = 400;  xs[1] = 0; xs[2] = 90; xs[3] = 5000;
    ys[0] = 300;  ys[1] = 0; ys[2] = 60; ys[3] = 10;
    cs[0] = 4;    cs[1] = 0; cs[2] = 3;  cs[3] = 2;
  endtask

  initial begin
    int lat, wcnt, base_d;
    longint unsigned exp34;
    rst = 1'b1;
    tabulate = 1'b0;
    for (int i = 0; i < K; i++) begin
      xs[i] = 0; ys[i] = 0; cs[i] = 0;
    end
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    check_outputs("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Reference vector with an empty cluster and an x saturation.
    load_req033();
    run("vec033", 0, lat);
    chk("vec033 x3_sat", xo[3], 2047);

    // Rounding behaviour on a half-way quotient.
    load_req033();
    xs[0] = 7; cs[0] = 2;
`ifdef CENTROID_ROUND_EN
    exp34 = 4;
`else
    exp34 = 3;
`endif
    run("round034", 0, lat);
    chk("round034 x0", xo[0], exp34);

    // Re-trigger while busy must be ignored.
    for (int i = 0; i < K; i++) begin
      xs[i] = $urandom_range(0, 100000);
      ys[i] = $urandom_range(0, 100000);
      cs[i] = $urandom_range(1, 200);
    end
    run("retrig035", 5, lat);

    // Reset while waiting on cluster 2's divider.
    load_req033();
    base_d = done_cnt;
    @(negedge clk);
    tabulate = 1'b1;
    @(posedge clk); #1;
    tabulate = 1'b0;
    wcnt = 0;
    while (!(dut.state_q == ST_WAIT && dut.idx_q == 2) && wcnt < LIMIT) begin
      @(posedge clk); #1;
      wcnt++;
    end
    chk("abort036 reached_wait2", (wcnt < LIMIT), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    chk("abort036 busy", busy, 0);
    chk("abort036 done", done, 0);
    check_outputs("abort036");
    repeat (60) @(posedge clk);
    #1;
    chk("abort036 no_done", done_cnt - base_d, 0);
    load_req033();
    run("after036", 0, lat);

    // All clusters empty: fixed K+2 latency, no divisions.
    for (int i = 0; i < K; i++) begin
      xs[i] = $urandom; ys[i] = $urandom; cs[i] = 0;
    end
    run("zero037", 0, lat);
    chk("zero037 latency", lat, K + 2);

    // Area saturation.
    load_req033();
    cs[1] = 70000; xs[1] = 35000000; ys[1] = 7000000;
    run("area038", 0, lat);
    chk("area038 area1", ao[1], 65535);

    // Randomized runs including empty clusters and saturating quotients.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < K; i++) begin
        cs[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 5000);
        xs[i] = ($urandom_range(0, 4) == 0) ? $urandom : $urandom_range(0, 5000000);
        ys[i] = ($urandom_range(0, 4) == 0) ? $urandom : $urandom_range(0, 3000000);
      end
      run($sformatf("rand%0d", r), (r == 2) ? 3 : 0, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/centroid_scheduler.md
CENTROID_SCHEDULER -- requirements
Module: centroid_scheduler

Interface
REQ-001 SHALL have parameter K, default 4, number of clusters.
REQ-002 SHALL have parameter WIDTH, default 32, width of sums, counts and divider operands.
REQ-003 SHALL have port clk_in, input, 1, the single clock.
REQ-004 SHALL have port rst_in, input, 1, reset (synchronous and active-high).
REQ-005 SHALL have port tabulate_in, input, 1, one-cycle pulse that starts a centroid computation.
REQ-006 SHALL have port x_sum_in[K-1:0], input, WIDTH each, per-cluster x accumulator.
REQ-007 SHALL have port y_sum_in[K-1:0], input, WIDTH each, per-cluster y accumulator.
REQ-008 SHALL have port count_in[K-1:0], input, WIDTH each, per-cluster pixel count.
REQ-009 SHALL have port busy_out, input-side status output, 1, high from snapshot until done.
REQ-010 SHALL have ports x_out[K-1:0] (11), y_out[K-1:0] (10) and area_out[K-1:0] (16), all outputs, holding per-cluster centroid and area.
REQ-011 SHALL have port valid_out[K-1:0], output, 1 each, result valid for that cluster.
REQ-012 SHALL have port done_out, output, 1, one-cycle pulse when all K clusters are resolved.

Function
REQ-013 SHALL time-share one divider instance across all 2K divisions, issued in fixed order: cluster 0 x, cluster 0 y, cluster 1 x, and so on up to cluster K-1 y.
REQ-014 SHALL use FSM states IDLE -> SNAP -> ISSUE -> WAIT -> (ISSUE | FINISH) -> IDLE.
REQ-015 In IDLE, tabulate_in SHALL snapshot all x_sum_in, y_sum_in and count_in into internal registers; SNAP SHALL be taken on the next cycle, and busy_out SHALL rise on that same cycle.
REQ-016 On entry to SNAP, every valid_out SHALL clear and every area_out[i] SHALL load min(count[i], 16'hFFFF).
REQ-017 ISSUE SHALL assert the divider start for exactly one cycle, with the selected sum as dividend and count[i] as divisor, then go to WAIT.
REQ-018 WAIT SHALL hold until the divider's data_valid_out, then write the quotient to the selected x_out or y_out and advance the cluster/axis index.
REQ-019 A quotient wider than its output SHALL saturate: x_out to 2047, y_out to 1023.
REQ-020 If count[i]==0, both divisions for cluster i SHALL be skipped (no divider start, 1 cycle per skipped cluster); x_out[i] and y_out[i] SHALL hold their previous values, and valid_out[i] SHALL stay 0.
REQ-021 valid_out[i] SHALL set in the cycle the y quotient of cluster i is written.
REQ-022 After the last index, FINISH SHALL pulse done_out for one cycle, drop busy_out and return to IDLE.
REQ-023 tabulate_in while busy_out=1 SHALL be ignored, with no queueing.
REQ-024 Changes on the *_in buses after the snapshot SHALL NOT affect the running computation.
REQ-025 If all counts are 0, done_out SHALL pulse K+2 cycles after tabulate_in, with all valid_out=0.

Reset
REQ-026 rst_in SHALL set state to IDLE, and busy_out, done_out, all valid_out, x_out, y_out and area_out to 0.
REQ-027 rst_in SHALL also reset the divider instance.
REQ-028 rst_in asserted mid-computation SHALL abort it; no done_out SHALL be produced for the aborted run.

Configuration
REQ-029 With CENTROID_ROUND_EN defined, the dividend SHALL be sum + (count>>1), giving round-to-nearest; the addition SHALL be computed in WIDTH+1 bits and saturated to WIDTH.
REQ-030 Without CENTROID_ROUND_EN, the quotient SHALL be truncated (floor).

Structure
REQ-031 A shared package SHALL hold the FSM state enum and the constants X_W=11, Y_W=10, AREA_W=16 with their saturation limits.
REQ-032 The sole sub-module SHALL be the codebase's existing iterative divider, instantiated once with WIDTH; its remainder, error and busy outputs SHALL be unused.

Verification
REQ-033 K=4; sums x={400,0,90,5000}, y={300,0,60,10}, counts={4,0,3,2}; pulse tabulate_in -> x_out={100,-,30,2047}, y_out={75,-,20,5}, valid_out={1,0,1,1}, area_out={4,0,3,2}, one done_out pulse.
REQ-034 x_sum=7, count=2: without the macro -> x_out=3; with CENTROID_ROUND_EN -> x_out=4.
REQ-035 Second tabulate_in pulse 5 cycles after the first, with changed sums -> results match the first snapshot and exactly one done_out occurs.
REQ-036 rst_in asserted while in WAIT for cluster 2 -> next cycle busy_out=0, all outputs 0, no done_out; a subsequent tabulate_in completes normally.
REQ-037 All counts 0 -> done_out exactly K+2 cycles after tabulate_in, no divider start observed, all valid_out=0.
REQ-038 count_in[1]=70000 -> area_out[1]=65535.
